// File: rtl/miriscv_mem_resp_queue.sv
// miriscv_mem_resp_queue: M-stage memory-data stage with an in-order response queue.
//
// Tracks up to OUTST data-memory requests in flight. Responses that arrive before their
// load reaches M are buffered. A response that arrives in the same cycle the load retires
// is forwarded directly. Load data is aligned and sign- or zero-extended to XLEN. A kill
// flushes the queue; responses still owed for flushed requests are counted and discarded.
//
// Ports:
//   clk_i, arst_i            clock, asynchronous active-high reset
//   issue_*                  request accepted by memory (size code, low address bits)
//   issue_ready_o            room for another request (registered state only)
//   data_rvalid_i/rdata_i    in-order memory responses, one per issued request
//   cu_stall_mp_i/kill_mp_i  M-stage stall and kill from the control unit
//   m_*                      M-stage instruction info and ALU/MDU results
//   mp_*                     writeback port, stall request, misaligned-load flag
//
// Size codes: BYTE=0 HALF=1 WORD=2 DOUBLE=3 UBYTE=4 UHALF=5 UWORD=6.
// Writeback source codes: ALU_DATA=0 MDU_DATA=1 LSU_DATA=2.
module miriscv_mem_resp_queue #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned OUTST        = 2,
  parameter int unsigned MEM_ACCESS_W = 3,
  parameter int unsigned GPR_ADDR_W   = 5,
  parameter int unsigned WB_SRC_W     = 2
) (
  input  logic                       clk_i,
  input  logic                       arst_i,
  input  logic                       issue_i,
  input  logic [MEM_ACCESS_W-1:0]    issue_size_i,
  input  logic [$clog2(XLEN/8)-1:0]  issue_off_i,
  output logic                       issue_ready_o,
  input  logic                       data_rvalid_i,
  input  logic [XLEN-1:0]            data_rdata_i,
  input  logic                       cu_stall_mp_i,
  input  logic                       cu_kill_mp_i,
  input  logic                       m_valid_i,
  input  logic                       m_mem_req_i,
  input  logic                       m_gpr_wr_en_i,
  input  logic [GPR_ADDR_W-1:0]      m_gpr_wr_addr_i,
  input  logic [WB_SRC_W-1:0]        m_gpr_src_sel_i,
  input  logic [XLEN-1:0]            m_alu_result_i,
  input  logic [XLEN-1:0]            m_mdu_result_i,
  output logic                       mp_valid_o,
  output logic                       mp_gpr_wr_en_o,
  output logic [GPR_ADDR_W-1:0]      mp_gpr_wr_addr_o,
  output logic [XLEN-1:0]            mp_gpr_wr_data_o,
  output logic                       mp_stall_req_o,
  output logic                       mp_misaligned_o
);

  localparam int unsigned OFF_W = $clog2(XLEN / 8);
  localparam int unsigned PTR_W = (OUTST > 1) ? $clog2(OUTST) : 1;
  localparam int unsigned CNT_W = $clog2(OUTST + 1);

  localparam logic [MEM_ACCESS_W-1:0] SzByte   = MEM_ACCESS_W'(0);
  localparam logic [MEM_ACCESS_W-1:0] SzHalf   = MEM_ACCESS_W'(1);
  localparam logic [MEM_ACCESS_W-1:0] SzWord   = MEM_ACCESS_W'(2);
  localparam logic [MEM_ACCESS_W-1:0] SzDouble = MEM_ACCESS_W'(3);
  localparam logic [MEM_ACCESS_W-1:0] SzUbyte  = MEM_ACCESS_W'(4);
  localparam logic [MEM_ACCESS_W-1:0] SzUhalf  = MEM_ACCESS_W'(5);
  localparam logic [MEM_ACCESS_W-1:0] SzUword  = MEM_ACCESS_W'(6);

  localparam logic [WB_SRC_W-1:0] MduData = WB_SRC_W'(1);
  localparam logic [WB_SRC_W-1:0] LsuData = WB_SRC_W'(2);

  logic [MEM_ACCESS_W-1:0] size_q [OUTST];
  logic [OFF_W-1:0]        off_q  [OUTST];
  logic [XLEN-1:0]         data_q [OUTST];
  logic [OUTST-1:0]        dv_q, dv_d;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rs_ptr_q, rs_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic                    rsp_store;
  logic                    head_dv;
  logic                    avail;
  logic                    retire;
  logic [XLEN-1:0]         head_data;
  logic [MEM_ACCESS_W-1:0] head_size;
  logic [OFF_W-1:0]        head_off;
  logic [XLEN-1:0]         head_sh;
  logic [XLEN-1:0]         ld_data;
  logic                    ld_ok;
  logic [CNT_W:0]          occ_plus_drop;
  int                      occ_n;
  int                      drop_n;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == int'(OUTST) - 1) ? '0 : p + 1'b1;
  endfunction

  // A response only lands in the queue when no flushed request is still owed one.
  assign rsp_store = data_rvalid_i & (drop_q == '0);

  assign head_dv   = dv_q[rd_ptr_q];
  // Same-cycle bypass: the response being written is the one the head is waiting for.
  assign avail     = head_dv | (rsp_store & (rs_ptr_q == rd_ptr_q) & (occ_q != '0));
  assign head_data = head_dv ? data_q[rd_ptr_q] : data_rdata_i;
  assign head_size = size_q[rd_ptr_q];
  assign head_off  = off_q[rd_ptr_q];
  assign head_sh   = head_data >> {head_off, 3'b000};

  assign retire = m_valid_i & m_mem_req_i & avail & ~cu_stall_mp_i & ~cu_kill_mp_i;

  assign occ_plus_drop = {1'b0, occ_q} + {1'b0, drop_q};
  assign issue_ready_o = occ_plus_drop < (CNT_W + 1)'(OUTST);

  // Load alignment and extension.
  always_comb begin
    ld_ok   = 1'b1;
    ld_data = '0;
    case (head_size)
      SzByte:  ld_data = XLEN'($signed(head_sh[7:0]));
      SzUbyte: ld_data = XLEN'(head_sh[7:0]);
      SzHalf: begin
        if (!head_off[0]) ld_data = XLEN'($signed(head_sh[15:0]));
        else              ld_ok = 1'b0;
      end
      SzUhalf: begin
        if (!head_off[0]) ld_data = XLEN'(head_sh[15:0]);
        else              ld_ok = 1'b0;
      end
      SzWord: begin
        if (head_off[1:0] == 2'b00) ld_data = XLEN'($signed(head_sh[31:0]));
        else                        ld_ok = 1'b0;
      end
      SzUword: begin
        if (XLEN == 64 && head_off[1:0] == 2'b00) ld_data = XLEN'(head_sh[31:0]);
        else                                      ld_ok = 1'b0;
      end
      SzDouble: begin
        if (XLEN == 64 && head_off == '0) ld_data = head_sh;
        else                              ld_ok = 1'b0;
      end
      default: ld_ok = 1'b0;
    endcase
  end

  // Writeback and stall outputs.
  assign mp_valid_o       = m_valid_i;
  assign mp_stall_req_o   = m_valid_i & m_mem_req_i & ~cu_kill_mp_i & ~avail;
  assign mp_gpr_wr_en_o   = m_gpr_wr_en_i & m_valid_i & ~cu_stall_mp_i & ~mp_stall_req_o;
  assign mp_gpr_wr_addr_o = m_gpr_wr_addr_i;
  assign mp_misaligned_o  = ~ld_ok & avail & m_mem_req_i & m_valid_i;

  always_comb begin
    if (m_gpr_src_sel_i == LsuData)      mp_gpr_wr_data_o = ld_data;
    else if (m_gpr_src_sel_i == MduData) mp_gpr_wr_data_o = m_mdu_result_i;
    else                                 mp_gpr_wr_data_o = m_alu_result_i;
  end

  // Next-state for pointers, counters and data-valid flags.
  always_comb begin
    wr_ptr_d = issue_i   ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rs_ptr_d = rsp_store ? ptr_inc(rs_ptr_q) : rs_ptr_q;
    rd_ptr_d = retire    ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    occ_n    = int'(occ_q) + int'(issue_i) - int'(retire);
    drop_n   = int'(drop_q) - int'(data_rvalid_i && drop_q != '0);

    dv_d = dv_q;
    if (issue_i)   dv_d[wr_ptr_q] = 1'b0;
    if (rsp_store) dv_d[rs_ptr_q] = 1'b1;
    if (retire)    dv_d[rd_ptr_q] = 1'b0;

    if (cu_kill_mp_i) begin
      // Every request without a response yet, plus one issued now, still owes a response.
      // A response arriving now settles one of those debts against the pre-flush state.
      drop_n   = int'(drop_q) + (int'(occ_q) - $countones(dv_q)) + int'(issue_i)
               - int'(data_rvalid_i);
      occ_n    = 0;
      dv_d     = '0;
      rd_ptr_d = wr_ptr_d;
      rs_ptr_d = wr_ptr_d;
    end

    occ_d  = CNT_W'(occ_n);
    drop_d = CNT_W'(drop_n);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_ptr_q <= '0;
      rs_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      drop_q   <= '0;
      dv_q     <= '0;
      for (int i = 0; i < int'(OUTST); i++) begin
        size_q[i] <= '0;
        off_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rs_ptr_q <= rs_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      drop_q   <= drop_d;
      dv_q     <= dv_d;
      if (issue_i) begin
        size_q[wr_ptr_q] <= issue_size_i;
        off_q[wr_ptr_q]  <= issue_off_i;
      end
      if (rsp_store) data_q[rs_ptr_q] <= data_rdata_i;
    end
  end

  a_issue_when_ready: assert property (@(posedge clk_i) disable iff (arst_i)
    issue_i |-> issue_ready_o);

  a_rsp_expected: assert property (@(posedge clk_i) disable iff (arst_i)
    data_rvalid_i |-> (occ_q != '0 || drop_q != '0));

endmodule

// File: doc/miriscv_mem_resp_queue.md
# miriscv_mem_resp_queue

Parametrised memory-data stage with a response queue. Tracks up to `OUTST` in-flight data-memory requests, buffers early `data_rvalid_i` responses, and aligns and sign- or zero-extends load data for `XLEN` 32 or 64. It produces the writeback data and the M-stage stall request. Kills discard responses that are still in flight. Sits between the execute-stage LSU request issue and the writeback port of the GPR file.

## Interface

Parameters:
- `XLEN`, 32 — data width; 32 or 64 only.
- `OUTST`, 2 — maximum outstanding requests; 1..8.

Ports:
- `clk_i` in 1 — clock.
- `arst_i` in 1 — reset; asynchronous, active-high.
- `issue_i` in 1 — request accepted by memory this cycle (req & gnt).
- `issue_size_i` in `MEM_ACCESS_W` — access size code of the issued request.
- `issue_off_i` in `$clog2(XLEN/8)` — low address bits of the issued request.
- `issue_ready_o` out 1 — a new request may be issued.
- `data_rvalid_i` in 1 — memory response valid. Exactly one response per issued request, returned in order; stores also respond.
- `data_rdata_i` in `XLEN` — memory response data.
- `cu_stall_mp_i` in 1 — M-stage stall from the control unit.
- `cu_kill_mp_i` in 1 — M-stage kill / pipeline flush.
- `m_valid_i` in 1 — M-stage instruction valid.
- `m_mem_req_i` in 1 — M-stage instruction is a load or store.
- `m_gpr_wr_en_i` in 1 — instruction writes the GPR file.
- `m_gpr_wr_addr_i` in `GPR_ADDR_W` — destination register.
- `m_gpr_src_sel_i` in `WB_SRC_W` — writeback source: `LSU_DATA`, `ALU_DATA` or `MDU_DATA`.
- `m_alu_result_i` in `XLEN` — ALU result.
- `m_mdu_result_i` in `XLEN` — MDU result.
- `mp_valid_o` out 1 — equals `m_valid_i`.
- `mp_gpr_wr_en_o` out 1 — GPR write enable.
- `mp_gpr_wr_addr_o` out `GPR_ADDR_W` — GPR write address.
- `mp_gpr_wr_data_o` out `XLEN` — GPR write data.
- `mp_stall_req_o` out 1 — stall request to the control unit.
- `mp_misaligned_o` out 1 — the retiring load has an illegal size/offset combination.

## Operation

- Queue storage:
  - `OUTST` entries, each {size, off, data[XLEN], dv}.
  - Three pointers, each wrapping modulo `OUTST`: `wr_ptr` (issue), `rs_ptr` (next response), `rd_ptr` (retire).
  - Occupancy counter `occ` (0..`OUTST`) and drop counter `drop` (0..`OUTST`).
- Issue: when `issue_i` is high, write {size, off, dv=0} at `wr_ptr` and increment `wr_ptr`.
- `issue_ready_o` = (`occ` + `drop`) < `OUTST`. Issuing while not ready is illegal; an SVA assertion checks it.
- Response handling when `data_rvalid_i` is high:
  - If `drop` > 0: discard the data and decrement `drop`.
  - Otherwise: store the data at `rs_ptr`, set dv=1, increment `rs_ptr`.
  - A response with `occ`==0 and `drop`==0 is illegal; an SVA assertion checks it.
- Head response availability `avail` = head dv, or (`data_rvalid_i` & `drop`==0 & `rs_ptr`==`rd_ptr` & `occ`>0). The second case is a same-cycle bypass. Head data is the bypassed `data_rdata_i` when head dv=0, otherwise the stored data.
- Retire: `retire` = `m_valid_i` & `m_mem_req_i` & `avail` & ~`cu_stall_mp_i` & ~`cu_kill_mp_i`. On retire, clear head dv and increment `rd_ptr`.
- Load extraction uses the head size and offset, and extends the result to `XLEN`:
  - BYTE/UBYTE: any offset.
  - HALF/UHALF: offset % 2 == 0 only.
  - WORD: offset % 4 == 0.
  - UWORD and DOUBLE (XLEN=64 only): UWORD at offset % 4 == 0; DOUBLE at offset 0.
  - Any other combination: result 0 and `mp_misaligned_o`=1, asserted only while `avail` & `m_mem_req_i` & `m_valid_i`.
- Writeback mux: `LSU_DATA` selects the extracted load data, `MDU_DATA` selects the MDU result, all other codes select the ALU result.
- `mp_gpr_wr_en_o` = `m_gpr_wr_en_i` & `m_valid_i` & ~`cu_stall_mp_i` & ~`mp_stall_req_o`.
- `mp_stall_req_o` = `m_valid_i` & `m_mem_req_i` & ~`cu_kill_mp_i` & ~`avail`.
- Kill (`cu_kill_mp_i`=1):
  - Next-state `occ`=0; all dv cleared; `rd_ptr`, `rs_ptr` := `wr_ptr` (+1 if `issue_i` that cycle).
  - `drop` := `drop` + (entries with no response yet) + `issue_i` − (`data_rvalid_i` consumed this cycle).
  - A response arriving in the kill cycle is counted against the old state before the flush.
- Simultaneous issue, response and retire in one cycle are all legal: `occ` += `issue_i` − `retire`.

## Timing

- Reset (async, `arst_i`=1): pointers 0, `occ`=0, `drop`=0, all dv=0. Hence `issue_ready_o`=1, `mp_stall_req_o`=0 unless `m_valid_i` & `m_mem_req_i`, and `mp_misaligned_o`=0.
- Reset released mid-transaction discards all state; the memory side is reset together with the block.
- Latency:
  - A response arriving in the same cycle the load sits in M retires with 0 added cycles (bypass).
  - A buffered response retires in the first cycle its load is in M and unstalled.
- All outputs except `issue_ready_o` are combinational from inputs and registered state; `issue_ready_o` depends on registered state only.
- Full: with `occ`=`OUTST`, `issue_ready_o`=0. It rises in the cycle after a retire or kill frees an entry, never combinationally from `retire`.
- Wrap-around: pointers wrap for any `OUTST`, including non-power-of-two values; full and empty are distinguished by `occ`, not by pointer equality.

## Test plan

- XLEN=32, OUTST=2: issue LBU at off 3, response 0x80FF_1234 in the same cycle the load is in M -> no stall, wr_data=0x0000_0080, wr_en=1.
- Two back-to-back LW issues, both responses arrive while M is stalled 3 cycles -> both buffered, `issue_ready_o`=0 while full; on release they retire on consecutive cycles with the correct data in order.
- Load in M with no response -> `mp_stall_req_o`=1 and wr_en=0 for 4 cycles; response 0xDEAD_BEEF -> stall drops and the data is written that cycle.
- Kill with 2 outstanding requests and no responses received -> `drop`=2; the next two rvalids are discarded; a fresh LH at off 2 then returns sign-extended 0xFFFF_8001 from rdata 0x8001_0000.
- XLEN=64: LWU at off 4 with rdata 0x9000_0001_0000_0000 -> 0x0000_0000_9000_0001; LD at off 4 -> `mp_misaligned_o`=1, data 0.
- Assert `arst_i` mid-burst with `occ`=2 -> `occ`=0 and `issue_ready_o`=1 immediately; ALU writeback passes ALU data unchanged.
